// File: rtl/im_sram_rd_slave.sv
// im_sram_rd_slave: AXI4 read-only slave in front of a single-port
// instruction SRAM. Each beat costs two cycles: one SRAM access cycle
// (CEB low) followed by a response cycle that holds R until accepted.
module im_sram_rd_slave #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int MEM_AW    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  // AR channel
  input  logic [ID_BITS-1:0]   ARID_S,
  input  logic [ADDR_BITS-1:0] ARADDR_S,
  input  logic [LEN_BITS-1:0]  ARLEN_S,
  input  logic [2:0]           ARSIZE_S,
  input  logic [1:0]           ARBURST_S,
  input  logic                 ARVALID_S,
  output logic                 ARREADY_S,
  // R channel
  output logic [ID_BITS-1:0]   RID_S,
  output logic [DATA_BITS-1:0] RDATA_S,
  output logic [1:0]           RRESP_S,
  output logic                 RLAST_S,
  output logic                 RVALID_S,
  input  logic                 RREADY_S,
  // SRAM macro
  output logic                 CEB,
  output logic                 WEB,
  output logic [MEM_AW-1:0]    A,
  input  logic [DATA_BITS-1:0] DO
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic [ID_BITS-1:0]  r_id;
  logic [MEM_AW-1:0]   r_addr;
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS-1:0] r_beat;

  logic w_last;
  logic w_unused;

  // Size, burst type, byte offset and high address bits carry no meaning here
  assign w_unused = ^{ARSIZE_S, ARBURST_S, ARADDR_S};

  assign w_last    = (r_beat == r_len);

  // All handshake/SRAM controls decode from state only, so an async reset
  // drops RVALID and raises CEB immediately
  assign ARREADY_S = (r_state == S_IDLE);
  assign RVALID_S  = (r_state == S_RESP);
  assign RLAST_S   = (r_state == S_RESP) && w_last;
  assign RID_S     = r_id;
  assign RDATA_S   = DO;            // SRAM holds DO while CEB is high
  assign RRESP_S   = 2'b00;
  assign CEB       = (r_state != S_ACCESS);
  assign WEB       = 1'b1;
  assign A         = r_addr;

  // Burst sequencer: latch AR, access SRAM, hold R until accepted, repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ARVALID_S) begin
            r_id    <= ARID_S;
            r_addr  <= ARADDR_S[MEM_AW+1:2];
            r_len   <= ARLEN_S;
            r_beat  <= '0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP: begin
          if (RREADY_S) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_addr  <= r_addr + 1'b1;   // wraps modulo the SRAM depth
              r_state <= S_ACCESS;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_sram_rd_slave.sv
// Bench for im_sram_rd_slave: behavioural SRAM plus a burst-level reference
// (expected beat i of a burst = mem[(ARADDR/4 + i) mod 16K]).
module tb_im_sram_rd_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID_S = '0;
  logic [31:0] ARADDR_S = '0;
  logic [3:0]  ARLEN_S = '0;
  logic [2:0]  ARSIZE_S = 3'b010;
  logic [1:0]  ARBURST_S = 2'b01;
  logic        ARVALID_S = 1'b0;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S = 1'b0;
  logic        CEB, WEB;
  logic [13:0] A;
  logic [31:0] DO;

  int vecs = 0;
  int errs = 0;
  int ceb_cnt = 0;

  logic [31:0] mem [16384];

  // observations from the last do_read
  logic [31:0] obs_data[$];
  logic [7:0]  obs_id[$];
  logic        obs_last[$];
  logic [1:0]  obs_resp[$];
  int          first_lat;
  bit          timed_out;

  im_sram_rd_slave dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .CEB(CEB), .WEB(WEB), .A(A), .DO(DO)
  );

  always #5 clk = ~clk;

  // SRAM macro model
  always @(posedge clk) begin
    if (CEB === 1'b0) DO <= mem[A];
    if (CEB === 1'b0) ceb_cnt++;
  end

  function automatic logic [31:0] ref_word(input logic [31:0] addr, input int i);
    int w;
    w = ((addr >> 2) + i) % 16384;
    return mem[w];
  endfunction

  // Collector only: present one AR, gather beats. Cycle 0 = cycle the AR is
  // presented (and accepted); first_lat = cycle index where RVALID first seen.
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input int stall_pct,
                         input logic [2:0] size, input logic [1:0] burst);
    int cyc;
    int n;
    obs_data.delete(); obs_id.delete(); obs_last.delete(); obs_resp.delete();
    first_lat = -1; timed_out = 0;
    @(negedge clk);
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = size;
    ARBURST_S = burst; ARVALID_S = 1'b1; RREADY_S = 1'b0;
    cyc = 0;
    while (!ARREADY_S && cyc < 50) begin @(negedge clk); cyc++; end
    if (!ARREADY_S) begin timed_out = 1; ARVALID_S = 1'b0; return; end
    @(negedge clk);
    ARVALID_S = 1'b0;
    cyc = 1; n = 0;
    while (n <= int'(len) && cyc < 400) begin
      RREADY_S = ($urandom_range(99) >= stall_pct);
      if (RVALID_S && first_lat < 0) first_lat = cyc;
      if (RVALID_S && RREADY_S) begin
        obs_data.push_back(RDATA_S); obs_id.push_back(RID_S);
        obs_last.push_back(RLAST_S); obs_resp.push_back(RRESP_S);
        n++;
      end
      @(negedge clk); cyc++;
    end
    RREADY_S = 1'b0;
    if (n <= int'(len)) timed_out = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++; if (ARREADY_S !== 1'b1) begin errs++; $display("FAIL reset_arready got=%b exp=1", ARREADY_S); end
    vecs++; if (RVALID_S !== 1'b0) begin errs++; $display("FAIL reset_rvalid got=%b exp=0", RVALID_S); end
    vecs++; if (RLAST_S !== 1'b0) begin errs++; $display("FAIL reset_rlast got=%b exp=0", RLAST_S); end
    vecs++; if (RID_S !== 8'h00) begin errs++; $display("FAIL reset_rid got=%h exp=00", RID_S); end
    vecs++; if (RRESP_S !== 2'b00) begin errs++; $display("FAIL reset_rresp got=%b exp=00", RRESP_S); end
    vecs++; if (CEB !== 1'b1) begin errs++; $display("FAIL reset_ceb got=%b exp=1", CEB); end
    vecs++; if (WEB !== 1'b1) begin errs++; $display("FAIL reset_web got=%b exp=1", WEB); end
    vecs++; if (A !== 14'h0) begin errs++; $display("FAIL reset_a got=%h exp=0000", A); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    mem[16'h0010] = 32'h1234_5678;
    do_read(8'h05, 32'h40, 4'd0, 0, 3'b010, 2'b01);
    vecs++; if (timed_out || obs_data.size() != 1) begin errs++; $display("FAIL single_beats got=%0d exp=1", obs_data.size()); end
    else begin
      vecs++; if (first_lat != 2) begin errs++; $display("FAIL single_latency got=%0d exp=2", first_lat); end
      vecs++; if (obs_data[0] !== 32'h1234_5678) begin errs++; $display("FAIL single_data got=%h exp=12345678", obs_data[0]); end
      vecs++; if (obs_id[0] !== 8'h05) begin errs++; $display("FAIL single_id got=%h exp=05", obs_id[0]); end
      vecs++; if (obs_last[0] !== 1'b1) begin errs++; $display("FAIL single_last got=%b exp=1", obs_last[0]); end
      vecs++; if (obs_resp[0] !== 2'b00) begin errs++; $display("FAIL single_resp got=%b exp=00", obs_resp[0]); end
    end
    vecs++; if (ARREADY_S !== 1'b1) begin errs++; $display("FAIL single_arready_after got=%b exp=1", ARREADY_S); end
  endtask

  task automatic test_burst_bp();
    logic [31:0] held_d;
    logic        held_l;
    int n, stall, cyc, c0;
    logic [31:0] got[$];
    logic        lst[$];
    for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'hA0 + i;
    @(negedge clk);
    c0 = ceb_cnt;
    ARID_S = 8'h07; ARADDR_S = 32'h100; ARLEN_S = 4'd3; ARSIZE_S = 3'b010;
    ARBURST_S = 2'b01; ARVALID_S = 1'b1;
    @(negedge clk);
    ARVALID_S = 1'b0;
    n = 0; stall = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      RREADY_S = 1'b1;
      if (RVALID_S && n == 1 && stall < 3) begin
        RREADY_S = 1'b0;
        if (stall > 0) begin
          vecs++; if (RDATA_S !== held_d || RLAST_S !== held_l) begin errs++;
            $display("FAIL bp_stable got=%h/%b exp=%h/%b", RDATA_S, RLAST_S, held_d, held_l); end
        end
        held_d = RDATA_S; held_l = RLAST_S; stall++;
      end
      if (RVALID_S && RREADY_S) begin got.push_back(RDATA_S); lst.push_back(RLAST_S); n++; end
      @(negedge clk); cyc++;
    end
    RREADY_S = 1'b0;
    vecs++; if (got.size() != 4) begin errs++; $display("FAIL bp_beats got=%0d exp=4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vecs++; if (got[i] !== 32'hA0 + i || lst[i] !== (i == 3)) begin errs++;
          $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, got[i], lst[i], 32'hA0 + i, (i == 3)); end
      end
    end
    vecs++; if (ceb_cnt - c0 != 4) begin errs++; $display("FAIL bp_ceb_pulses got=%0d exp=4", ceb_cnt - c0); end
  endtask

  task automatic test_wrap();
    do_read(8'h09, 32'h0000_FFFC, 4'd1, 0, 3'b010, 2'b01);
    vecs++; if (timed_out || obs_data.size() != 2) begin errs++; $display("FAIL wrap_beats got=%0d exp=2", obs_data.size()); end
    else begin
      vecs++; if (obs_data[0] !== mem[16'h3FFF]) begin errs++; $display("FAIL wrap_beat0 got=%h exp=%h", obs_data[0], mem[16'h3FFF]); end
      vecs++; if (obs_data[1] !== mem[0]) begin errs++; $display("FAIL wrap_beat1 got=%h exp=%h", obs_data[1], mem[0]); end
    end
  endtask

  task automatic test_busy();
    bit busy_bad, first_done, ar2_taken;
    int cyc, last1_cyc, ar2_cyc, rv2_cyc;
    logic [31:0] d2;
    logic [7:0]  id2;
    busy_bad = 0; first_done = 0; ar2_taken = 0;
    last1_cyc = -1; ar2_cyc = -1; rv2_cyc = -1; d2 = '0; id2 = '0;
    @(negedge clk);
    ARID_S = 8'h21; ARADDR_S = 32'h300; ARLEN_S = 4'd2; ARVALID_S = 1'b1; RREADY_S = 1'b1;
    @(negedge clk);
    // second request held from now on while the first burst is in progress
    ARID_S = 8'h12; ARADDR_S = 32'h400; ARLEN_S = 4'd0;
    cyc = 0;
    while (rv2_cyc < 0 && cyc < 100) begin
      if (ar2_taken) ARVALID_S = 1'b0;
      if (!first_done && ARREADY_S) busy_bad = 1;
      if (!first_done && RVALID_S && RREADY_S && RLAST_S) begin first_done = 1; last1_cyc = cyc; end
      else if (first_done && !ar2_taken && ARVALID_S && ARREADY_S) begin ar2_taken = 1; ar2_cyc = cyc; end
      if (ar2_taken && RVALID_S) begin rv2_cyc = cyc; d2 = RDATA_S; id2 = RID_S; end
      @(negedge clk); cyc++;
    end
    ARVALID_S = 1'b0;
    @(negedge clk);
    RREADY_S = 1'b0;
    vecs++; if (busy_bad) begin errs++; $display("FAIL busy_arready got=1 exp=0 during burst"); end
    vecs++; if (ar2_cyc != last1_cyc + 1 || last1_cyc < 0) begin errs++; $display("FAIL busy_accept_cyc got=%0d exp=%0d", ar2_cyc, last1_cyc + 1); end
    vecs++; if (rv2_cyc != ar2_cyc + 2 || rv2_cyc <= last1_cyc) begin errs++; $display("FAIL busy_rvalid2_cyc got=%0d exp=%0d", rv2_cyc, ar2_cyc + 2); end
    vecs++; if (id2 !== 8'h12) begin errs++; $display("FAIL busy_rid2 got=%h exp=12", id2); end
    vecs++; if (d2 !== mem[16'h100]) begin errs++; $display("FAIL busy_data2 got=%h exp=%h", d2, mem[16'h100]); end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    bit seen;
    @(negedge clk);
    ARID_S = 8'h33; ARADDR_S = 32'h200; ARLEN_S = 4'd3; ARVALID_S = 1'b1; RREADY_S = 1'b1;
    @(negedge clk);
    ARVALID_S = 1'b0;
    n = 0; cyc = 0;
    while (cyc < 50) begin
      if (RVALID_S && n == 1) break;
      if (RVALID_S && RREADY_S) n++;
      @(negedge clk); cyc++;
    end
    RREADY_S = 1'b0;
    vecs++; if (!(RVALID_S && n == 1)) begin errs++; $display("FAIL rstmid_reach_beat1 got=%0d exp=1", n); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (RVALID_S !== 1'b0) begin errs++; $display("FAIL rstmid_rvalid got=%b exp=0", RVALID_S); end
    vecs++; if (CEB !== 1'b1) begin errs++; $display("FAIL rstmid_ceb got=%b exp=1", CEB); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    RREADY_S = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (RVALID_S) seen = 1; end
    RREADY_S = 1'b0;
    vecs++; if (seen) begin errs++; $display("FAIL rstmid_no_more_beats got=1 exp=0"); end
    vecs++; if (ARREADY_S !== 1'b1) begin errs++; $display("FAIL rstmid_arready got=%b exp=1", ARREADY_S); end
    do_read(8'h44, 32'h0000_0A08, 4'd0, 0, 3'b010, 2'b01);
    vecs++; if (timed_out || obs_data.size() != 1 || obs_data[0] !== ref_word(32'hA08, 0) || obs_id[0] !== 8'h44) begin
      errs++; $display("FAIL rstmid_fresh_read got=%0d beats exp=1 data=%h id=44", obs_data.size(), ref_word(32'hA08, 0)); end
  endtask

  task automatic test_ignored();
    logic [31:0] d0, d1;
    int lat;
    do_read(8'h3C, 32'h0000_1230, 4'd1, 0, 3'b010, 2'b01);
    d0 = (obs_data.size() > 0) ? obs_data[0] : 32'hX;
    d1 = (obs_data.size() > 1) ? obs_data[1] : 32'hX;
    lat = first_lat;
    do_read(8'h3C, 32'hFFFF_1233, 4'd1, 0, 3'b000, 2'b00);
    vecs++; if (timed_out || obs_data.size() != 2) begin errs++; $display("FAIL ign_beats got=%0d exp=2", obs_data.size()); end
    else begin
      vecs++; if (obs_data[0] !== ref_word(32'h1230, 0) || obs_data[0] !== d0) begin errs++; $display("FAIL ign_beat0 got=%h exp=%h", obs_data[0], ref_word(32'h1230, 0)); end
      vecs++; if (obs_data[1] !== ref_word(32'h1230, 1) || obs_data[1] !== d1) begin errs++; $display("FAIL ign_beat1 got=%h exp=%h", obs_data[1], ref_word(32'h1230, 1)); end
      vecs++; if (first_lat != 2 || lat != 2) begin errs++; $display("FAIL ign_latency got=%0d/%0d exp=2", first_lat, lat); end
      vecs++; if (obs_resp[0] !== 2'b00 || obs_resp[1] !== 2'b00) begin errs++; $display("FAIL ign_resp got=%b/%b exp=00", obs_resp[0], obs_resp[1]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    for (int t = 0; t < 15; t++) begin
      id = 8'($urandom); addr = $urandom; len = 4'($urandom_range(15));
      if (t % 4 == 0) addr[15:2] = 14'h3FF8;   // bias some bursts across the wrap
      do_read(id, addr, len, 35, 3'($urandom), 2'($urandom));
      vecs++; if (timed_out || obs_data.size() != int'(len) + 1) begin errs++;
        $display("FAIL rnd%0d_beats got=%0d exp=%0d", t, obs_data.size(), int'(len) + 1); end
      else begin
        vecs++; if (first_lat != 2) begin errs++; $display("FAIL rnd%0d_latency got=%0d exp=2", t, first_lat); end
        for (int i = 0; i <= int'(len); i++) begin
          vecs++;
          if (obs_data[i] !== ref_word(addr, i) || obs_id[i] !== id ||
              obs_last[i] !== (i == int'(len)) || obs_resp[i] !== 2'b00) begin
            errs++;
            $display("FAIL rnd%0d_beat%0d got=%h/%h/%b/%b exp=%h/%h/%b/00", t, i,
                     obs_data[i], obs_id[i], obs_last[i], obs_resp[i],
                     ref_word(addr, i), id, (i == int'(len)));
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_burst_bp();
    test_wrap();
    test_busy();
    test_reset_mid();
    test_ignored();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/im_sram_rd_slave.md
Name: im_sram_rd_slave

Overview:
- AXI4 read-only slave. Sits downstream of the instruction-fetch AXI master, behind the bus interconnect.
- Accepts AR requests, including INCR bursts. Reads a single-port instruction SRAM macro and returns data on the R channel.
- Holds the R channel stable under backpressure.
- Slave-side ID width is 8 bits: master ID plus interconnect tag.

Parameters:
- ID_BITS, 8, AR/R ID width (slave side)
- ADDR_BITS, 32, AXI address width
- DATA_BITS, 32, AXI data width and SRAM word width
- LEN_BITS, 4, ARLEN width
- MEM_AW, 14, SRAM word-address width (16K words)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- ARID_S  in  ID_BITS  read address ID
- ARADDR_S  in  ADDR_BITS  byte address
- ARLEN_S  in  LEN_BITS  beats minus 1
- ARSIZE_S  in  3  transfer size (ignored; word accesses only)
- ARBURST_S  in  2  burst type (treated as INCR)
- ARVALID_S  in  1  address valid
- ARREADY_S  out  1  address ready
- RID_S  out  ID_BITS  response ID
- RDATA_S  out  DATA_BITS  read data
- RRESP_S  out  2  response (always OKAY = 2'b00)
- RLAST_S  out  1  last beat
- RVALID_S  out  1  data valid
- RREADY_S  in  1  data ready
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low (tied 1)
- A  out  MEM_AW  SRAM word address
- DO  in  DATA_BITS  SRAM read data

Behaviour:
- SRAM model: DO updates at a rising edge where CEB=0 is sampled. DO holds its value while CEB=1.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: ARREADY_S=1. On AR handshake (ARVALID_S & ARREADY_S), latch:
    - id_q <= ARID_S
    - addr_q <= ARADDR_S[MEM_AW+1:2]
    - len_q <= ARLEN_S
    - beat_q <= 0
    - Go to ACCESS.
  - ACCESS (1 cycle): CEB=0, A=addr_q, ARREADY_S=0 → RESP.
  - RESP:
    - Outputs: RVALID_S=1, RDATA_S=DO, RID_S=id_q, RLAST_S=(beat_q==len_q), CEB=1, ARREADY_S=0.
    - No R handshake: stay in RESP. All R outputs hold stable.
    - R handshake and RLAST_S=1: go to IDLE.
    - R handshake and RLAST_S=0: beat_q+1, addr_q+1, go to ACCESS.
- Latency and throughput:
  - AR handshake at edge T → RVALID_S high from edge T+2.
  - Steady throughput is one beat per 2 cycles.
- Address arithmetic:
  - addr_q increments modulo 2^MEM_AW; wraps 0x3FFF→0x0000 with no error.
  - ARADDR_S[1:0] and bits above MEM_AW+1 are ignored.
- ARREADY_S is combinational from state only, never from ARVALID_S. An ARVALID_S held during a burst waits until IDLE.
- Back-to-back: a new AR is accepted in the first IDLE cycle after the last-beat handshake, i.e. one-cycle gap minimum.
- In IDLE: RVALID_S=0, RLAST_S=0, CEB=1. RID_S and RDATA_S are don't-care; the implementation drives id_q and DO.
- Reset, asynchronous and active-high, including mid-burst:
  - State → IDLE; id_q, addr_q, len_q, beat_q → 0.
  - Output reset values: ARREADY_S=1, RVALID_S=0, RLAST_S=0, RID_S=0, RRESP_S=0, CEB=1, WEB=1, A=0.
  - An in-flight burst is abandoned with no further R beats.
- RRESP_S is always 2'b00. ARSIZE_S and ARBURST_S values are never reported as errors.

Test Plan:
- Single read: preload word 0x0010 = 0x1234_5678; AR ADDR=0x40, LEN=0, ID=0x05, RREADY_S=1 → RVALID_S two cycles after AR handshake, with RDATA_S=0x12345678, RID_S=0x05, RLAST_S=1, RRESP_S=0; then ARREADY_S=1 next cycle.
- Burst with backpressure: AR ADDR=0x100, LEN=3; words 0x40..0x43 = 0xA0..0xA3; RREADY_S low 3 cycles on beat 1 → beats A0,A1,A2,A3 in order; beat 1 RDATA_S/RLAST_S stable while stalled; RLAST_S only on A3; CEB pulses exactly 4 times.
- Address wrap: AR ADDR=0xFFFC (word 0x3FFF), LEN=1 → beat 0 from word 0x3FFF, beat 1 from word 0x0000.
- AR while busy: second ARVALID_S (ID=0x12) asserted during the first burst's RESP → ARREADY_S stays 0 until IDLE; second burst's first RVALID_S never overlaps the first burst's RLAST_S handshake; RID_S=0x12 on the second burst.
- Reset mid-burst: assert rst during RESP of beat 1 of a LEN=3 burst → RVALID_S=0 and CEB=1 immediately (asynchronous); after release ARREADY_S=1; a fresh LEN=0 read returns correct data.
- Ignored fields: ARSIZE_S=3'b000, ARBURST_S=2'b00, ARADDR_S[1:0]=2'b11 → identical data and timing to the aligned word read, RRESP_S=0.
